// File: rtl/line_fill_ram.sv
// Word-addressed backing RAM for the cache refill path: single-word writes,
// line reads returned as a critical-word-first burst that wraps within the line.
module line_fill_ram #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 10,
  parameter int LINE_WORDS   = 4,
  parameter int READ_LATENCY = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_last,
  output logic                  busy
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; valid must not depend on ready, and ready only exists in IDLE.
  localparam int OW = $clog2(LINE_WORDS);
  localparam int LW = ADDR_WIDTH - OW;
  localparam logic [OW-1:0] LAST_BEAT = OW'(LINE_WORDS - 1);
  localparam logic [3:0]    WAIT_LOAD = (READ_LATENCY > 0) ? 4'(READ_LATENCY - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [LW-1:0]         line_q;
  logic [OW-1:0]         off_q;
  logic [OW-1:0]         cnt_q;
  logic [3:0]            wait_q;
  logic [OW-1:0]         beat_off;
  logic                  accept;
  logic                  beat_done;

  assign accept    = req_valid && req_ready;
  assign beat_done = rsp_valid && rsp_ready;
  // Offset arithmetic is OW bits wide so the beat index wraps inside the line.
  assign beat_off  = off_q + cnt_q;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && !req_write) state_nxt = (READ_LATENCY == 0) ? BURST : WAIT;
      WAIT:    if (wait_q == 4'd0) state_nxt = BURST;
      BURST:   if (beat_done && cnt_q == LAST_BEAT) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      line_q <= '0;
      off_q  <= '0;
      cnt_q  <= '0;
      wait_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept && !req_write) begin
        line_q <= req_addr[ADDR_WIDTH-1:OW];
        off_q  <= req_addr[OW-1:0];
        cnt_q  <= '0;
        wait_q <= WAIT_LOAD;
      end else if (state == WAIT && wait_q != 4'd0) begin
        wait_q <= wait_q - 4'd1;
      end
      if (beat_done) cnt_q <= cnt_q + OW'(1);
    end
  end

  // Array has no reset so contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (accept && req_write) mem[req_addr] <= req_wdata;
  end

  always_comb begin
    req_ready = (state == IDLE);
    busy      = (state != IDLE);
    rsp_valid = (state == BURST);
    rsp_last  = rsp_valid && (cnt_q == LAST_BEAT);
    rsp_data  = rsp_valid ? mem[{line_q, beat_off}] : '0;
  end

endmodule

// File: tb/tb_line_fill_ram.sv
// Directed bench for line_fill_ram: a READ_LATENCY=3 instance and a
// READ_LATENCY=0 instance share stimulus, selected by sel0.
module tb_line_fill_ram;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_valid, req_write, rsp_ready, sel0;
  logic [9:0] req_addr;
  logic [7:0] req_wdata;

  logic       r3_req_ready, r3_rsp_valid, r3_rsp_last, r3_busy;
  logic [7:0] r3_rsp_data;
  logic       r0_req_ready, r0_rsp_valid, r0_rsp_last, r0_busy;
  logic [7:0] r0_rsp_data;
  logic       v3, v0;

  logic       o_req_ready, o_rsp_valid, o_rsp_last, o_busy;
  logic [7:0] o_rsp_data;

  logic [7:0] exp_q[$];
  int         n_total = 0;
  int         n_bad   = 0;

  assign v3 = req_valid && !sel0;
  assign v0 = req_valid && sel0;
  assign o_req_ready = sel0 ? r0_req_ready : r3_req_ready;
  assign o_rsp_valid = sel0 ? r0_rsp_valid : r3_rsp_valid;
  assign o_rsp_last  = sel0 ? r0_rsp_last  : r3_rsp_last;
  assign o_busy      = sel0 ? r0_busy      : r3_busy;
  assign o_rsp_data  = sel0 ? r0_rsp_data  : r3_rsp_data;

  line_fill_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(10), .LINE_WORDS(4), .READ_LATENCY(3)) dut3 (
    .clk(clk), .reset(reset), .req_valid(v3), .req_ready(r3_req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(r3_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(r3_rsp_data),
    .rsp_last(r3_rsp_last), .busy(r3_busy)
  );

  line_fill_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(10), .LINE_WORDS(4), .READ_LATENCY(0)) dut0 (
    .clk(clk), .reset(reset), .req_valid(v0), .req_ready(r0_req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(r0_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(r0_rsp_data),
    .rsp_last(r0_rsp_last), .busy(r0_busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Driver tasks start and end on a falling edge.
  task automatic do_write(input logic [9:0] a, input logic [7:0] d);
    check("wr_req_ready", o_req_ready, 1'b1);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = a;
    req_wdata = d;
    @(negedge clk);
    req_valid = 1'b0;
    req_write = 1'b0;
  endtask

  task automatic read_line(input logic [9:0] addr,
                           input logic [7:0] e0, input logic [7:0] e1,
                           input logic [7:0] e2, input logic [7:0] e3,
                           input int lat, input bit stall, input int abort_beat,
                           input bit hold_wr, input logic [9:0] h_addr, input logic [7:0] h_data);
    int n;
    int beats;
    int k;
    int guard;
    bit pat[4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    exp_q = {};
    exp_q.push_back(e0);
    exp_q.push_back(e1);
    exp_q.push_back(e2);
    exp_q.push_back(e3);
    check("rd_req_ready", o_req_ready, 1'b1);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = addr;
    rsp_ready = 1'b1;
    @(negedge clk);
    if (hold_wr) begin
      req_write = 1'b1;
      req_addr  = h_addr;
      req_wdata = h_data;
    end else begin
      req_valid = 1'b0;
    end
    n = 1;
    while (!o_rsp_valid && n < 40) begin
      check("wait_busy", o_busy, 1'b1);
      @(negedge clk);
      n++;
    end
    check("first_beat_lat", n, lat + 1);
    beats = 0;
    k = 0;
    guard = 0;
    while (beats < 4 && guard < 100) begin
      check("rsp_valid", o_rsp_valid, 1'b1);
      check("rsp_data", o_rsp_data, exp_q[0]);
      check("rsp_last", o_rsp_last, beats == 3);
      check("burst_busy", o_busy, 1'b1);
      if (hold_wr) check("burst_req_ready", o_req_ready, 1'b0);
      if (beats == abort_beat) begin
        reset = 1'b1;
        #1;
        check("abort_rsp_valid", o_rsp_valid, 1'b0);
        check("abort_req_ready", o_req_ready, 1'b1);
        check("abort_busy", o_busy, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        rsp_ready = 1'b1;
        return;
      end
      rsp_ready = stall ? pat[k % 4] : 1'b1;
      k++;
      if (rsp_ready) begin
        void'(exp_q.pop_front());
        beats++;
      end
      @(negedge clk);
      guard++;
    end
    check("handshakes", beats, 4);
    check("end_rsp_valid", o_rsp_valid, 1'b0);
    check("end_req_ready", o_req_ready, 1'b1);
    check("end_busy", o_busy, 1'b0);
    rsp_ready = 1'b1;
    if (hold_wr) begin
      @(negedge clk);
      req_valid = 1'b0;
      req_write = 1'b0;
    end
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b1;
    sel0      = 1'b0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel0 = (s == 1);
      #1;
      check("rst_req_ready", o_req_ready, 1'b1);
      check("rst_rsp_valid", o_rsp_valid, 1'b0);
      check("rst_rsp_last", o_rsp_last, 1'b0);
      check("rst_rsp_data", o_rsp_data, 8'h00);
      check("rst_busy", o_busy, 1'b0);
    end
    sel0 = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // straight line read, then critical-word-first wrap
    do_write(10'h010, 8'hA0);
    do_write(10'h011, 8'hA1);
    do_write(10'h012, 8'hA2);
    do_write(10'h013, 8'hA3);
    read_line(10'h010, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 3, 1'b0, -1, 1'b0, 10'h0, 8'h0);
    read_line(10'h012, 8'hA2, 8'hA3, 8'hA0, 8'hA1, 3, 1'b0, -1, 1'b0, 10'h0, 8'h0);

    // back-pressure on the response channel
    read_line(10'h010, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 3, 1'b1, -1, 1'b0, 10'h0, 8'h0);

    // reset during beat 2, contents must survive
    read_line(10'h010, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 3, 1'b0, 1, 1'b0, 10'h0, 8'h0);
    @(negedge clk);
    read_line(10'h011, 8'hA1, 8'hA2, 8'hA3, 8'hA0, 3, 1'b0, -1, 1'b0, 10'h0, 8'h0);

    // write held during a burst only lands once the responder is idle
    do_write(10'h3FC, 8'hC0);
    do_write(10'h3FD, 8'hC1);
    do_write(10'h3FE, 8'hC2);
    do_write(10'h3FF, 8'hC3);
    read_line(10'h010, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 3, 1'b0, -1, 1'b1, 10'h3FF, 8'h5A);
    read_line(10'h3FC, 8'hC0, 8'hC1, 8'hC2, 8'h5A, 3, 1'b0, -1, 1'b0, 10'h0, 8'h0);
    read_line(10'h3FE, 8'hC2, 8'h5A, 8'hC0, 8'hC1, 3, 1'b1, -1, 1'b0, 10'h0, 8'h0);

    // zero-latency instance
    sel0 = 1'b1;
    @(negedge clk);
    do_write(10'h020, 8'h60);
    do_write(10'h021, 8'h61);
    do_write(10'h022, 8'h62);
    do_write(10'h023, 8'h63);
    read_line(10'h020, 8'h60, 8'h61, 8'h62, 8'h63, 0, 1'b0, -1, 1'b0, 10'h0, 8'h0);
    read_line(10'h023, 8'h63, 8'h60, 8'h61, 8'h62, 0, 1'b1, -1, 1'b0, 10'h0, 8'h0);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
